fpmult_normalize_stage: RTL

//  Pipelined normalization stage of the FP multiplier, directly upstream of the rounding stage.

---
 rtl/fpmult_normalize_stage.sv | 127 ++++++++++++
 1 files changed

// File: rtl/fpmult_normalize_stage.sv
// FP multiplier normalize stage: 0/1-bit shift, RNE round-up decision, M/M+1 and E/E+1 pairs.
// Optional FPMULT_UNDERFLOW_FLUSH_EN flushes results whose normalized exponent is <= 0.
module fpmult_normalize_stage #(
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*FRAC_W+1:0]        ProdM,
  input  logic signed [EXP_W+1:0]    SumE,
  input  logic                       Sp_in,
  input  logic [4:0]                 InputExc_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FRAC_W:0]            RoundM,
  output logic [FRAC_W:0]            RoundMP,
  output logic [EXP_W:0]             RoundE,
  output logic [EXP_W:0]             RoundEP,
  output logic                       Sp,
  output logic                       GRS,
  output logic [4:0]                 InputExc
);

  localparam int PW = 2 * (FRAC_W + 1);
  localparam logic [FRAC_W:0] M_ONE = 1;
  localparam logic [EXP_W:0]  E_ONE = 1;
  localparam logic [EXP_W+1:0] E_INC = 1;

  logic va, vb, ld_a, ld_b;

  assign ld_b      = !vb || out_ready;
  assign ld_a      = !va || ld_b;
  assign in_ready  = ld_a;
  assign out_valid = vb;

  logic                    top, lsb, rnd, stk, zero;
  logic [FRAC_W-1:0]       frac_n;
  logic signed [EXP_W+1:0] e_n;
  logic                    grs_n;

  always_comb begin
    top    = ProdM[PW-1];
    zero   = (ProdM == '0);
    frac_n = top ? ProdM[PW-2 -: FRAC_W] : ProdM[PW-3 -: FRAC_W];
    lsb    = top ? ProdM[FRAC_W+1] : ProdM[FRAC_W];
    rnd    = top ? ProdM[FRAC_W] : ProdM[FRAC_W-1];
    stk    = top ? |ProdM[FRAC_W-1:0] : |ProdM[FRAC_W-2:0];
    e_n    = top ? SumE + E_INC : SumE;
    grs_n  = rnd && (lsb || stk);
    if (zero) begin
      frac_n = '0;
      e_n    = '0;
      grs_n  = 1'b0;
    end
  end

  logic [FRAC_W-1:0]       fa;
  logic signed [EXP_W+1:0] ea;
  logic                    ga, spa;
  logic [4:0]              xa;

  always_ff @(posedge clk) begin
    if (rst) begin
      va  <= 1'b0;
      fa  <= '0;
      ea  <= '0;
      ga  <= 1'b0;
      spa <= 1'b0;
      xa  <= '0;
    end else if (ld_a) begin
      va <= in_valid;
      if (in_valid) begin
        fa  <= frac_n;
        ea  <= e_n;
        ga  <= grs_n;
        spa <= Sp_in;
        xa  <= InputExc_in;
      end
    end
  end

`ifdef FPMULT_UNDERFLOW_FLUSH_EN
  logic flush;
  assign flush = (ea <= 0);
`else
  logic flush;
  logic unused_esign;
  assign flush        = 1'b0;
  assign unused_esign = ea[EXP_W+1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vb       <= 1'b0;
      RoundM   <= '0;
      RoundMP  <= '0;
      RoundE   <= '0;
      RoundEP  <= '0;
      Sp       <= 1'b0;
      GRS      <= 1'b0;
      InputExc <= '0;
    end else if (ld_b) begin
      vb <= va;
      if (va) begin
        Sp <= spa;
        if (flush) begin
          RoundM   <= '0;
          RoundMP  <= '0;
          RoundE   <= '0;
          RoundEP  <= '0;
          GRS      <= 1'b0;
          InputExc <= xa | 5'b00010;
        end else begin
          RoundM   <= {1'b0, fa};
          RoundMP  <= {1'b0, fa} + M_ONE;
          RoundE   <= ea[EXP_W:0];
          RoundEP  <= ea[EXP_W:0] + E_ONE;
          GRS      <= ga;
          InputExc <= xa;
        end
      end
    end
  end

endmodule
